// File: rtl/adc_serial_responder.sv
// adc_serial_responder
// Emulates an MCP3201-style serial ADC on the FPGA fabric. The controller's
// adc_clk and adc_cs_n are resynchronised into clk_clk and edge-detected. The
// captured sample is shifted out MSB first, one bit per adc_clk falling edge,
// after LEAD_BITS leading zeros.
module adc_serial_responder #(
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 2,
    parameter int SYNC_STG  = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              adc_clk,
    input  logic              adc_cs_n,
    output logic              adc_dout,
    output logic              adc_dout_oe,
    input  logic [DATA_W-1:0] sample_value,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [15:0]       frame_count
);

    // Edge counter saturates one past the last data bit.
    localparam int MAX_CNT = LEAD_BITS + DATA_W + 1;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(LEAD_BITS + DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_DATA = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    logic [SYNC_STG-1:0] clk_sync_reg;
    logic [SYNC_STG-1:0] cs_sync_reg;
    logic                clk_prev_reg;
    logic                cs_prev_reg;

    state_t              state_reg;
    logic [CNT_W-1:0]    edge_cnt_reg;
    logic [DATA_W-1:0]   shadow_reg;
    logic                dout_reg;
    logic                oe_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                abort_reg;
    logic [15:0]         count_reg;

    logic                clk_s;
    logic                cs_s;
    logic                clk_fall;
    logic                cs_fall;
    logic                cs_rise;
    logic [CNT_W-1:0]    cnt_inc;

    // Synchronise the asynchronous serial clock and chip select.
    // Sync flops reset to the idle levels, so a held-high cs_n makes no false edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clk_sync_reg <= '0;
            cs_sync_reg  <= '1;
            clk_prev_reg <= 1'b0;
            cs_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STG-2:0], adc_clk};
            cs_sync_reg  <= {cs_sync_reg[SYNC_STG-2:0], adc_cs_n};
            clk_prev_reg <= clk_sync_reg[SYNC_STG-1];
            cs_prev_reg  <= cs_sync_reg[SYNC_STG-1];
        end
    end

    assign clk_s    = clk_sync_reg[SYNC_STG-1];
    assign cs_s     = cs_sync_reg[SYNC_STG-1];
    assign clk_fall = clk_prev_reg & ~clk_s;
    assign cs_fall  = cs_prev_reg & ~cs_s;
    assign cs_rise  = ~cs_prev_reg & cs_s;

    // Saturating next value of the falling-edge counter.
    always_comb begin
        cnt_inc = edge_cnt_reg;
        if (edge_cnt_reg != CNT_MAX) begin
            cnt_inc = edge_cnt_reg + CNT_W'(1);
        end
    end

    // Frame FSM: the captured word is shifted out MSB first, and every output is registered.
    // A chip-select rise takes priority over a coincident clock fall.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg    <= ST_IDLE;
            edge_cnt_reg <= '0;
            shadow_reg   <= '0;
            dout_reg     <= 1'b1;
            oe_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            abort_reg    <= 1'b0;
            count_reg    <= '0;
        end else begin
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        shadow_reg   <= sample_value;
                        edge_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        oe_reg       <= 1'b1;
                        dout_reg     <= 1'b0;
                        state_reg    <= ST_LEAD;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state_reg <= ST_IDLE;
                        oe_reg    <= 1'b0;
                        dout_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        if (state_reg == ST_TAIL) begin
                            done_reg  <= 1'b1;
                            count_reg <= count_reg + 16'd1;
                        end else begin
                            abort_reg <= 1'b1;
                        end
                    end else if (clk_fall) begin
                        edge_cnt_reg <= cnt_inc;
                        if (cnt_inc <= LEAD_LAST) begin
                            dout_reg <= 1'b0;
                        end else if (cnt_inc <= DATA_LAST) begin
                            dout_reg   <= shadow_reg[DATA_W-1];
                            shadow_reg <= {shadow_reg[DATA_W-2:0], 1'b0};
                            state_reg  <= (cnt_inc == DATA_LAST) ? ST_TAIL : ST_DATA;
                        end else begin
                            dout_reg  <= 1'b0;
                            state_reg <= ST_TAIL;
                        end
                    end
                end
            endcase
        end
    end

    assign adc_dout    = dout_reg;
    assign adc_dout_oe = oe_reg;
    assign busy        = busy_reg;
    assign frame_done  = done_reg;
    assign frame_abort = abort_reg;
    assign frame_count = count_reg;

endmodule

// File: tb/tb_adc_serial_responder.sv
// tb_adc_serial_responder
// Directed bench: acts as the controller, running adc_clk at clk/16 with an idle-high level.
// It samples adc_dout just before each adc_clk rise and compares with hand-computed words.
module tb_adc_serial_responder;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        adc_clk;
    logic        adc_cs_n;
    logic        adc_dout;
    logic        adc_dout_oe;
    logic [11:0] sample_value;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;
    logic [15:0] frame_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count = '0;

    always #5 clk_clk = ~clk_clk;

    adc_serial_responder #(
        .DATA_W(12), .LEAD_BITS(2), .SYNC_STG(2)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .adc_clk      (adc_clk),
        .adc_cs_n     (adc_cs_n),
        .adc_dout     (adc_dout),
        .adc_dout_oe  (adc_dout_oe),
        .sample_value (sample_value),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .frame_count  (frame_count)
    );

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // n adc_clk periods (fall, then rise); dout is captured just before each rise.
    task automatic adc_cycles(input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            adc_clk = 1'b0;
            wait_neg(8);
            rx = {rx[30:0], adc_dout};
            adc_clk = 1'b1;
            wait_neg(8);
        end
    endtask

    task automatic start_frame(input logic [11:0] v);
        sample_value = v;
        adc_cs_n = 1'b0;
        wait_neg(8);
    endtask

    // Raise cs_n, then count the pulses and find the first cycle in which oe is low.
    task automatic end_frame(output int n_done, output int n_abort, output int oe_lat);
        n_done = 0; n_abort = 0; oe_lat = 0;
        adc_cs_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wait_neg(1);
            if (frame_done)  n_done++;
            if (frame_abort) n_abort++;
            if (!adc_dout_oe && oe_lat == 0) oe_lat = i;
        end
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0; adc_clk = 1'b1; adc_cs_n = 1'b1; sample_value = '0;
        wait_neg(4);
        checks++;
        if ({adc_dout, adc_dout_oe, busy, frame_done, frame_abort} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 10000",
                     {adc_dout, adc_dout_oe, busy, frame_done, frame_abort});
        end
        checks++;
        if (frame_count !== 16'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", frame_count);
        end
        reset_reset_n = 1'b1;
        wait_neg(6);
        $display("reset released count=%0d", frame_count);
    endtask

    task automatic test_basic_frame();
        logic [31:0] rx; int nd, na, lat;
        start_frame(12'hA5C);
        checks++;
        if ({busy, adc_dout_oe, adc_dout} !== 3'b110) begin
            errors++; $display("FAIL basic_start: got %b expected 110", {busy, adc_dout_oe, adc_dout});
        end
        adc_cycles(15, rx);
        end_frame(nd, na, lat);
        exp_count++;
        $display("frame sample=a5c rx=%h done=%0d abort=%0d count=%0d", rx[14:0], nd, na, frame_count);
        checks++;
        if (rx[14:0] !== {2'b00, 12'hA5C, 1'b0}) begin
            errors++; $display("FAIL basic_bits: got %h expected %h", rx[14:0], {2'b00, 12'hA5C, 1'b0});
        end
        checks++;
        if (nd !== 1 || na !== 0) begin
            errors++; $display("FAIL basic_pulses: got done=%0d abort=%0d expected 1/0", nd, na);
        end
        checks++;
        if (frame_count !== exp_count) begin
            errors++; $display("FAIL basic_count: got %0d expected %0d", frame_count, exp_count);
        end
        checks++;
        if ({busy, adc_dout_oe, adc_dout} !== 3'b001) begin
            errors++; $display("FAIL basic_idle: got %b expected 001", {busy, adc_dout_oe, adc_dout});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rx1, rx2; int nd, na, lat;
        start_frame(12'hFFF);
        adc_cycles(15, rx1);
        sample_value = 12'h000;
        adc_cs_n = 1'b1;
        wait_neg(1);
        adc_cs_n = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            wait_neg(1);
            if (frame_done) nd++;
        end
        exp_count++;
        $display("frame sample=fff rx=%h done=%0d count=%0d", rx1[14:0], nd, frame_count);
        checks++;
        if (nd !== 1) begin
            errors++; $display("FAIL b2b_first_done: got %0d expected 1", nd);
        end
        checks++;
        if ({busy, adc_dout_oe, adc_dout} !== 3'b110) begin
            errors++; $display("FAIL b2b_restart: got %b expected 110", {busy, adc_dout_oe, adc_dout});
        end
        adc_cycles(15, rx2);
        end_frame(nd, na, lat);
        exp_count++;
        $display("frame sample=000 rx=%h done=%0d abort=%0d count=%0d", rx2[14:0], nd, na, frame_count);
        checks++;
        if (rx1[14:0] !== {2'b00, 12'hFFF, 1'b0}) begin
            errors++; $display("FAIL b2b_word1: got %h expected %h", rx1[14:0], {2'b00, 12'hFFF, 1'b0});
        end
        checks++;
        if (rx2[14:0] !== 15'h0000) begin
            errors++; $display("FAIL b2b_word2: got %h expected 0000", rx2[14:0]);
        end
        checks++;
        if (nd !== 1 || frame_count !== exp_count) begin
            errors++; $display("FAIL b2b_count: got done=%0d count=%0d expected 1/%0d", nd, frame_count, exp_count);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rx; int nd, na, lat;
        start_frame(12'h5A5);
        adc_cycles(6, rx);
        end_frame(nd, na, lat);
        $display("abort frame rx=%h done=%0d abort=%0d lat=%0d count=%0d", rx[5:0], nd, na, lat, frame_count);
        checks++;
        if (rx[5:0] !== 6'b000101) begin
            errors++; $display("FAIL abort_bits: got %b expected 000101", rx[5:0]);
        end
        checks++;
        if (na !== 1 || nd !== 0) begin
            errors++; $display("FAIL abort_pulses: got abort=%0d done=%0d expected 1/0", na, nd);
        end
        checks++;
        if (frame_count !== exp_count) begin
            errors++; $display("FAIL abort_count: got %0d expected %0d", frame_count, exp_count);
        end
        checks++;
        if (lat < 1 || lat > 3 || {adc_dout_oe, adc_dout} !== 2'b01) begin
            errors++; $display("FAIL abort_release: got lat=%0d oe/dout=%b expected <=3/01", lat, {adc_dout_oe, adc_dout});
        end
    endtask

    task automatic test_sample_change();
        logic [31:0] rx1, rx2; logic [14:0] word; int nd, na, lat;
        start_frame(12'h123);
        adc_cycles(4, rx1);
        sample_value = 12'h3FF;
        adc_cycles(11, rx2);
        end_frame(nd, na, lat);
        exp_count++;
        word = {rx1[3:0], rx2[10:0]};
        $display("frame sample=123->3ff rx=%h done=%0d count=%0d", word, nd, frame_count);
        checks++;
        if (word !== {2'b00, 12'h123, 1'b0}) begin
            errors++; $display("FAIL change_word: got %h expected %h", word, {2'b00, 12'h123, 1'b0});
        end
        checks++;
        if (nd !== 1 || frame_count !== exp_count) begin
            errors++; $display("FAIL change_count: got done=%0d count=%0d expected 1/%0d", nd, frame_count, exp_count);
        end
    endtask

    task automatic test_cs_high_clock();
        int viol = 0;
        adc_cs_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            adc_clk = 1'b0;
            for (int j = 0; j < 8; j++) begin
                wait_neg(1);
                if ({adc_dout, adc_dout_oe, busy, frame_done, frame_abort} !== 5'b10000) viol++;
            end
            adc_clk = 1'b1;
            for (int j = 0; j < 8; j++) begin
                wait_neg(1);
                if ({adc_dout, adc_dout_oe, busy, frame_done, frame_abort} !== 5'b10000) viol++;
            end
        end
        $display("cs high clocking: violating cycles=%0d count=%0d", viol, frame_count);
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL cs_high_idle: got %0d bad cycles expected 0", viol);
        end
        checks++;
        if (frame_count !== exp_count) begin
            errors++; $display("FAIL cs_high_count: got %0d expected %0d", frame_count, exp_count);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rx; int nd, na, lat;
        start_frame(12'h5A5);
        adc_cycles(9, rx);
        reset_reset_n = 1'b0;
        #1;
        exp_count = '0;
        checks++;
        if ({adc_dout, adc_dout_oe, busy, frame_done, frame_abort} !== 5'b10000 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b count=%0d expected 10000 count=0",
                     {adc_dout, adc_dout_oe, busy, frame_done, frame_abort}, frame_count);
        end
        adc_cs_n = 1'b1;
        wait_neg(3);
        reset_reset_n = 1'b1;
        wait_neg(6);
        start_frame(12'h800);
        adc_cycles(15, rx);
        end_frame(nd, na, lat);
        exp_count++;
        $display("frame sample=800 rx=%h done=%0d abort=%0d count=%0d", rx[14:0], nd, na, frame_count);
        checks++;
        if (rx[14:0] !== {2'b00, 12'h800, 1'b0}) begin
            errors++; $display("FAIL midreset_word: got %h expected %h", rx[14:0], {2'b00, 12'h800, 1'b0});
        end
        checks++;
        if (nd !== 1 || frame_count !== exp_count) begin
            errors++; $display("FAIL midreset_count: got done=%0d count=%0d expected 1/%0d", nd, frame_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_abort();
        test_sample_change();
        test_cs_high_clock();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
